// File: rtl/i2s_recv_pkg.sv
// ----------------------------------------------------------------------------
// i2s_recv_pkg
//   Shared definitions for the I2S receiver:
//     - rx_state_e : receiver FSM state encodings (RX_IDLE .. RX_WAIT_L)
//     - clogb2     : bits needed to hold a value; sizes the per-channel
//                    bit counter (NS = clogb2(NB-1))
// ----------------------------------------------------------------------------
package i2s_recv_pkg;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,  // after reset: wait for the first lrclk fall
    RX_SKIP_L  = 3'd1,  // drop the I2S one-bit delay slot of the left channel
    RX_SHIFT_L = 3'd2,  // capture NB left bits, MSB first
    RX_WAIT_R  = 3'd3,  // left done: ignore extra slot bits, wait for rise
    RX_SKIP_R  = 3'd4,  // drop the one-bit delay slot of the right channel
    RX_SHIFT_R = 3'd5,  // capture NB right bits, MSB first
    RX_DONE    = 3'd6,  // publish {left,right}
    RX_WAIT_L  = 3'd7   // ignore extra right slot bits, wait for next fall
  } rx_state_e;

  // Number of bits required to represent 'value' (minimum 1).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/i2s_recv.sv
// ----------------------------------------------------------------------------
// i2s_recv
//   I2S receiver. Deserialises one stereo frame (left then right, NB bits
//   each, MSB first, one-bit I2S delay after every lrclk edge) and hands the
//   completed {left,right} word to the consumer.
//
//   Handshake (rcv_rdy / rcv_ack):
//     rcv_rdy rises two clocks after the CBrise that samples the last right
//     bit, together with the new 'sample'. It stays high until a clock in
//     which rcv_ack=1, and is low from the next clock on. rcv_ack while
//     rcv_rdy=0 has no effect. If a new frame is published in the same clock
//     as rcv_ack, the new frame wins and rcv_rdy stays high. A frame
//     published while rcv_rdy is still high and not being acked overwrites
//     'sample' and pulses 'overrun' for one clock.
//
//   Ports:
//     clk        system clock, all logic on posedge
//     rst        asynchronous, active-low reset
//     lrclk      left/right clock (low = left, high = right), clk-synchronous
//     CBrise     one-clk strobe marking a BCLK rising edge; inbit sampled on it
//     inbit      serial data from the codec
//     sample     received frame: [DB-1:NB] left, [NB-1:0] right
//     rcv_rdy    sample holds a frame not yet acknowledged
//     rcv_ack    consumer has taken sample
//     overrun    one-clk pulse: frame completed while rcv_rdy still set
//     frame_err  one-clk pulse: lrclk edge before NB bits of a channel arrived
//     state_dbg  current FSM state (rx_state_e encoding), observation only
//
//   Register delays are not modelled; all state updates are zero-delay.
// ----------------------------------------------------------------------------
module i2s_recv
  import i2s_recv_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lrclk,
  input  logic                 CBrise,
  input  logic                 inbit,
  output logic [DATA_BITS-1:0] sample,
  output logic                 rcv_rdy,
  input  logic                 rcv_ack,
  output logic                 overrun,
  output logic                 frame_err,
  output logic [2:0]           state_dbg
);

  localparam int NB = DATA_BITS / 2;
  localparam int NS = clogb2(NB - 1);

  rx_state_e       state;
  rx_state_e       state_nxt;
  logic            err_nxt;

  logic            lr_q;
  logic            fall;
  logic            rise;
  logic            lr_edge;
  logic            cb;

  logic [NB-1:0]   shreg;
  logic [NB-1:0]   shreg_nxt;
  logic [NB-1:0]   left_q;
  logic [NS-1:0]   cnt;
  logic            cnt_zero;
  logic            in_shift;
  logic            in_skip;

  // --------------------------------------------------------------------------
  // lrclk edge detection. A BCLK strobe in the same clock as an lrclk edge is
  // masked, so bit counting always starts on the following strobe.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lr_q <= 1'b0;
    else      lr_q <= lrclk;
  end

  assign fall    = lr_q & ~lrclk;
  assign rise    = ~lr_q & lrclk;
  assign lr_edge = fall | rise;
  assign cb      = CBrise & ~lr_edge;

  assign cnt_zero  = (cnt == '0);
  assign shreg_nxt = {shreg[NB-2:0], inbit};
  assign in_shift  = (state == RX_SHIFT_L) || (state == RX_SHIFT_R);
  assign in_skip   = (state == RX_SKIP_L)  || (state == RX_SKIP_R);
  assign state_dbg = state;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM next-state. Any lrclk edge while skipping or shifting is a framing
  // error: a fall restarts at the new left channel, a rise means the left
  // half of this frame is lost so the whole frame is abandoned.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (fall) state_nxt = RX_SKIP_L;
      end
      RX_SKIP_L, RX_SKIP_R: begin
        if (lr_edge) begin
          err_nxt   = 1'b1;
          state_nxt = fall ? RX_SKIP_L : RX_WAIT_L;
        end else if (cb) begin
          state_nxt = (state == RX_SKIP_L) ? RX_SHIFT_L : RX_SHIFT_R;
        end
      end
      RX_SHIFT_L, RX_SHIFT_R: begin
        if (lr_edge) begin
          err_nxt   = 1'b1;
          state_nxt = fall ? RX_SKIP_L : RX_WAIT_L;
        end else if (cb && cnt_zero) begin
          state_nxt = (state == RX_SHIFT_L) ? RX_WAIT_R : RX_DONE;
        end
      end
      RX_WAIT_R: begin
        if (rise) state_nxt = RX_SKIP_R;
      end
      RX_DONE: begin
        // A fall landing in this clock already belongs to the next frame.
        state_nxt = fall ? RX_SKIP_L : RX_WAIT_L;
      end
      RX_WAIT_L: begin
        if (fall) state_nxt = RX_SKIP_L;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift register, bit counter and left-channel holding register.
  // The counter is loaded on the discarded delay-slot strobe so that cnt==0
  // marks the strobe carrying the NB-th (last) bit of the channel.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg  <= '0;
      cnt    <= '0;
      left_q <= '0;
    end else begin
      if (in_skip && cb) begin
        cnt <= NS'(NB - 1);
      end else if (in_shift && cb && !cnt_zero) begin
        cnt <= cnt - 1'b1;
      end

      if (in_shift && cb) shreg <= shreg_nxt;

      if ((state == RX_SHIFT_L) && cb && cnt_zero) left_q <= shreg_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Output register and handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample    <= '0;
      rcv_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (state == RX_DONE) && rcv_rdy && !rcv_ack;
      frame_err <= err_nxt;

      if (state == RX_DONE) begin
        sample  <= {left_q, shreg};
        rcv_rdy <= 1'b1;
      end else if (rcv_ack) begin
        rcv_rdy <= 1'b0;
      end
    end
  end

endmodule
